datapath_ctrl: RTL and testbench
================================

Name: datapath_ctrl

Overview:
- Microcoded control unit that sits directly upstream of the 4-bit x/y datapath.
- Drives the datapath's imm, op_sel, en_x, en_y and y_sel inputs, and reads back its zero flag.
- Executes a short program from an internal 16x8 instruction store, loaded through a write port while idle.
- Host interface is a start/busy/done handshake, with a sticky error flag raised by an instruction-count watchdog.

Parameters:
- MAX_INSTR, 255: instructions executed per run before the watchdog aborts; legal range 1..255.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- prog_we  in  1  program-store write enable; honoured only in IDLE.
- prog_addr  in  4  program-store write address.
- prog_data  in  8  instruction to write.
- start  in  1  begin a run at address 0; honoured only in IDLE.
- zero  in  1  datapath zero flag (x == 0).
- imm  out  4  immediate to datapath.
- op_sel  out  2  datapath ALU select.
- en_x  out  1  x register load enable.
- en_y  out  1  y register load enable.
- y_sel  out  1  y source select (1 = imm).
- busy  out  1  high in FETCH and EXEC.
- done  out  1  one-cycle pulse at end of run.
- error  out  1  watchdog abort; sticky until next accepted start or reset.
- instr_cnt  out  8  instructions executed in current/last run.

Behaviour:
- Instruction format: [7:5] opcode, [4] ignored, [3:0] operand (imm or target).
- Opcode 0, LDY: y_sel=1, en_y=1, imm=operand, op_sel=0.
- Opcode 1, MOVX: op_sel=3, en_x=1.
- Opcode 2, NOTX: op_sel=1, en_x=1.
- Opcode 3, ADDX: op_sel=2, en_x=1.
- Opcode 4, BZ: if zero, pc<=operand.
- Opcode 5, JMP: pc<=operand.
- Opcode 6, HALT: end the run.
- Opcode 7, NOP: no datapath action.
- Control outputs are decoded from the registered instruction register (ir) and are valid only in EXEC. In every other state all control outputs are 0.
- States and transitions:
  - IDLE: start → FETCH, with pc<=0, instr_cnt<=0, error<=0.
  - FETCH: ir<=mem[pc], pc<=pc+1 (4-bit, 15 wraps to 0) → EXEC.
  - EXEC: executes ir. HALT → DONE; otherwise instr_cnt++ and → FETCH. If instr_cnt reaches MAX_INSTR here, set error=1 → DONE.
  - DONE: done=1 for this cycle → IDLE.
- Each instruction takes 2 cycles. Datapath registers capture on the EXEC→FETCH edge.
- BZ samples zero during its EXEC cycle, so it sees the result of the previous instruction.
- A HALT is not counted in instr_cnt.
- prog_we outside IDLE is ignored. start outside IDLE is ignored.
- prog_we and start in the same IDLE cycle: the write commits at that edge and the run starts at that edge. The first FETCH therefore sees the new contents if prog_addr=0.
- Reset, asynchronous, takes effect at any time including mid-run:
  - state IDLE; pc, ir, instr_cnt cleared to 0.
  - busy, done and error cleared to 0; all control outputs 0.
  - All 16 program-store entries set to 8'hC0 (HALT).
- instr_cnt holds its value after DONE until the next accepted start.

Test Plan:
- Arithmetic program, no branches:
  - Load 8'h05,20,40,01,60,05,60,C0 at addresses 0-7, then pulse start.
  - Control pattern in EXEC cycles matches y<=5, x<=y, x<=~x, y<=1, x<=x+y, y<=5, x<=x+y.
  - x ends at 0 and zero=1.
  - done pulses 17 cycles after start; instr_cnt=7; error=0.
- Countdown loop: program LDY 3, MOVX, LDY 15, BZ 6, ADDX, JMP 3, HALT.
  - BZ is taken after x reaches 0.
  - instr_cnt=13; x=0; done pulses once.
- Watchdog:
  - Program JMP 0 (8'hA0) at address 0, MAX_INSTR=255.
  - error=1 and done pulse after 255 instructions.
  - error remains high in IDLE and clears on the next start.
- Reset mid-run:
  - Assert reset during EXEC of an ADDX.
  - busy, en_x and all controls drop to 0 immediately; state is IDLE.
  - A subsequent start with no reload runs the HALT at address 0: done pulses 3 cycles after start, instr_cnt=0.
- Ignored inputs:
  - prog_we and start pulsed while busy change neither program contents nor pc.
  - prog_we to address 0 together with start in IDLE executes the newly written instruction.

Source files
------------

// File: rtl/datapath_ctrl.sv
// Microcoded control unit for the 4-bit x/y datapath: runs a 16x8 program store under a start/busy/done handshake.
// Each instruction takes two cycles (FETCH, EXEC); an instruction-count watchdog aborts runaway programs with a sticky error.
module datapath_ctrl #(
  parameter int unsigned MAX_INSTR = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       prog_we,
  input  logic [3:0] prog_addr,
  input  logic [7:0] prog_data,
  input  logic       start,
  input  logic       zero,
  output logic [3:0] imm,
  output logic [1:0] op_sel,
  output logic       en_x,
  output logic       en_y,
  output logic       y_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] instr_cnt
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_EXEC  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    OP_LDY  = 3'd0,
    OP_MOVX = 3'd1,
    OP_NOTX = 3'd2,
    OP_ADDX = 3'd3,
    OP_BZ   = 3'd4,
    OP_JMP  = 3'd5,
    OP_HALT = 3'd6,
    OP_NOP  = 3'd7
  } opcode_t;

  typedef struct packed {
    logic [3:0] imm;
    logic [1:0] op_sel;
    logic       en_x;
    logic       en_y;
    logic       y_sel;
  } ctrl_t;

  localparam logic [7:0] CNT_LAST = 8'(MAX_INSTR - 1);

  state_t     state;
  logic [3:0] pc;
  logic [6:0] ir;          // {opcode, operand}; instruction bit 4 carries no meaning
  logic [7:0] mem [16];
  ctrl_t      ctrl;

  function automatic ctrl_t decode(input logic [2:0] opc, input logic [3:0] operand);
    ctrl_t c;
    c = '0;
    case (opcode_t'(opc))
      OP_LDY:  begin c.y_sel = 1'b1; c.en_y = 1'b1; c.imm = operand; end
      OP_MOVX: begin c.op_sel = 2'd3; c.en_x = 1'b1; end
      OP_NOTX: begin c.op_sel = 2'd1; c.en_x = 1'b1; end
      OP_ADDX: begin c.op_sel = 2'd2; c.en_x = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Controls are registered alongside ir so they are live exactly during EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pc        <= 4'd0;
      ir        <= 7'd0;
      instr_cnt <= 8'd0;
      error     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      ctrl      <= '0;
      for (int i = 0; i < 16; i++) mem[i] <= 8'hC0;
    end else begin
      case (state)
        S_IDLE: begin
          if (prog_we) mem[prog_addr] <= prog_data;
          if (start) begin
            state     <= S_FETCH;
            pc        <= 4'd0;
            instr_cnt <= 8'd0;
            error     <= 1'b0;
            busy      <= 1'b1;
          end
        end
        S_FETCH: begin
          ir    <= {mem[pc][7:5], mem[pc][3:0]};
          ctrl  <= decode(mem[pc][7:5], mem[pc][3:0]);
          pc    <= pc + 4'd1;
          state <= S_EXEC;
        end
        S_EXEC: begin
          ctrl <= '0;
          if (opcode_t'(ir[6:4]) == OP_HALT) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            instr_cnt <= instr_cnt + 8'd1;
            if ((opcode_t'(ir[6:4]) == OP_BZ && zero) || opcode_t'(ir[6:4]) == OP_JMP)
              pc <= ir[3:0];
            if (instr_cnt == CNT_LAST) begin
              error <= 1'b1;
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= S_FETCH;
            end
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imm    = ctrl.imm;
  assign op_sel = ctrl.op_sel;
  assign en_x   = ctrl.en_x;
  assign en_y   = ctrl.en_y;
  assign y_sel  = ctrl.y_sel;

endmodule

// File: tb/tb_datapath_ctrl.sv
// Bench for datapath_ctrl with a small behavioural x/y datapath closing the zero-flag loop.
module tb_datapath_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic       start;
  logic       zero;
  logic [3:0] imm;
  logic [1:0] op_sel;
  logic       en_x, en_y, y_sel;
  logic       busy, done, error;
  logic [7:0] instr_cnt;

  logic [3:0] x, y, alu;

  int n_chk  = 0;
  int n_fail = 0;

  datapath_ctrl #(.MAX_INSTR(255)) dut (
    .clk       (clk),
    .reset     (rst),
    .prog_we   (prog_we),
    .prog_addr (prog_addr),
    .prog_data (prog_data),
    .start     (start),
    .zero      (zero),
    .imm       (imm),
    .op_sel    (op_sel),
    .en_x      (en_x),
    .en_y      (en_y),
    .y_sel     (y_sel),
    .busy      (busy),
    .done      (done),
    .error     (error),
    .instr_cnt (instr_cnt)
  );

  always #5 clk = ~clk;

  // Reference datapath: 0 pass x, 1 ~x, 2 x+y, 3 y.
  always_comb begin
    alu = x;
    case (op_sel)
      2'd1: alu = ~x;
      2'd2: alu = x + y;
      2'd3: alu = y;
      default: alu = x;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= 4'd0;
      y <= 4'd0;
    end else begin
      if (en_x) x <= alu;
      if (en_y) y <= y_sel ? imm : alu;
    end
  end

  assign zero = (x == 4'd0);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [3:0] a, input logic [7:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick;
    prog_we = 1'b0;
  endtask

  // Starts a run and counts edges until done; optionally pokes prog_we/start mid-run.
  task automatic run(input int inject, output int edges);
    start = 1'b1;
    tick;
    start = 1'b0; prog_we = 1'b0;
    edges = 1;
    while (!done && edges < 1000) begin
      if (edges == inject) begin
        prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'hA0; start = 1'b1;
      end
      tick;
      prog_we = 1'b0; start = 1'b0;
      edges++;
    end
  endtask

  function automatic logic [8:0] ctl();
    return {imm, op_sel, en_x, en_y, y_sel};
  endfunction

  typedef struct {
    logic [7:0] instr;
    logic [8:0] exp_ctl;   // {imm, op_sel, en_x, en_y, y_sel}
    int         exp_edges;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [9];
  logic [8:0] arith_ctl [7];
  int e;

  initial begin
    vecs[0] = '{8'h05, {4'h5, 2'd0, 1'b0, 1'b1, 1'b1}, 5, 8'd1};
    vecs[1] = '{8'h1A, {4'hA, 2'd0, 1'b0, 1'b1, 1'b1}, 5, 8'd1};
    vecs[2] = '{8'h20, {4'h0, 2'd3, 1'b1, 1'b0, 1'b0}, 5, 8'd1};
    vecs[3] = '{8'h40, {4'h0, 2'd1, 1'b1, 1'b0, 1'b0}, 5, 8'd1};
    vecs[4] = '{8'h60, {4'h0, 2'd2, 1'b1, 1'b0, 1'b0}, 5, 8'd1};
    vecs[5] = '{8'h81, 9'd0, 5, 8'd1};
    vecs[6] = '{8'hA1, 9'd0, 5, 8'd1};
    vecs[7] = '{8'hC0, 9'd0, 3, 8'd0};
    vecs[8] = '{8'hE0, 9'd0, 5, 8'd1};

    arith_ctl[0] = {4'h5, 2'd0, 1'b0, 1'b1, 1'b1};
    arith_ctl[1] = {4'h0, 2'd3, 1'b1, 1'b0, 1'b0};
    arith_ctl[2] = {4'h0, 2'd1, 1'b1, 1'b0, 1'b0};
    arith_ctl[3] = {4'h1, 2'd0, 1'b0, 1'b1, 1'b1};
    arith_ctl[4] = {4'h0, 2'd2, 1'b1, 1'b0, 1'b0};
    arith_ctl[5] = {4'h5, 2'd0, 1'b0, 1'b1, 1'b1};
    arith_ctl[6] = {4'h0, 2'd2, 1'b1, 1'b0, 1'b0};

    rst = 1'b1; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 8'd0; start = 1'b0;
    tick; tick;
    rst = 1'b0;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_error", error, 1'b0);
    chk("reset_cnt", instr_cnt, 8'd0);
    chk("reset_ctl", ctl(), 9'd0);

    // Single-instruction decode table, each followed by HALT at address 1.
    for (int i = 0; i < 9; i++) begin
      load(4'd0, vecs[i].instr);
      load(4'd1, 8'hC0);
      start = 1'b1;
      tick;
      start = 1'b0;
      chk($sformatf("fetch_ctl[%0d]", i), ctl(), 9'd0);
      tick;
      chk($sformatf("exec_ctl[%0d]", i), ctl(), vecs[i].exp_ctl);
      chk($sformatf("exec_busy[%0d]", i), busy, 1'b1);
      e = 2;
      while (!done && e < 50) begin tick; e++; end
      chk($sformatf("done_edges[%0d]", i), e, vecs[i].exp_edges);
      chk($sformatf("cnt[%0d]", i), instr_cnt, vecs[i].exp_cnt);
      tick;
    end

    // Arithmetic program: x ends at 0.
    load(4'd0, 8'h05); load(4'd1, 8'h20); load(4'd2, 8'h40); load(4'd3, 8'h01);
    load(4'd4, 8'h60); load(4'd5, 8'h05); load(4'd6, 8'h60); load(4'd7, 8'hC0);
    start = 1'b1;
    tick;
    start = 1'b0;
    for (int k = 0; k < 7; k++) begin
      tick;
      chk($sformatf("arith_ctl[%0d]", k), ctl(), arith_ctl[k]);
      tick;
    end
    tick;
    chk("arith_halt_ctl", ctl(), 9'd0);
    chk("arith_halt_done_early", done, 1'b0);
    tick;
    chk("arith_done_at_17", done, 1'b1);
    chk("arith_cnt", instr_cnt, 8'd7);
    chk("arith_error", error, 1'b0);
    chk("arith_x", x, 4'd0);
    chk("arith_zero", zero, 1'b1);
    tick;
    chk("arith_done_pulse", done, 1'b0);
    chk("arith_idle_busy", busy, 1'b0);
    chk("arith_cnt_hold", instr_cnt, 8'd7);

    // Countdown loop, with prog_we/start poked while busy.
    load(4'd0, 8'h03); load(4'd1, 8'h20); load(4'd2, 8'h0F); load(4'd3, 8'h86);
    load(4'd4, 8'h60); load(4'd5, 8'hA3); load(4'd6, 8'hC0);
    run(6, e);
    chk("loop_edges", e, 29);
    chk("loop_cnt", instr_cnt, 8'd13);
    chk("loop_x", x, 4'd0);
    tick;
    chk("loop_done_once", done, 1'b0);
    run(-1, e);
    chk("loop_rerun_edges", e, 29);
    chk("loop_rerun_cnt", instr_cnt, 8'd13);
    tick;

    // Watchdog.
    load(4'd0, 8'hA0);
    run(-1, e);
    chk("wd_edges", e, 511);
    chk("wd_error", error, 1'b1);
    chk("wd_cnt", instr_cnt, 8'd255);
    tick; tick; tick;
    chk("wd_error_sticky", error, 1'b1);
    chk("wd_idle_busy", busy, 1'b0);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("wd_error_clear", error, 1'b0);
    chk("wd_restart_busy", busy, 1'b1);

    // Reset during EXEC of ADDX.
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load(4'd0, 8'h03); load(4'd1, 8'h60); load(4'd2, 8'hC0);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick; tick; tick;
    chk("rst_pre_addx", ctl(), {4'h0, 2'd2, 1'b1, 1'b0, 1'b0});
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 1'b0);
    chk("rst_ctl", ctl(), 9'd0);
    chk("rst_cnt", instr_cnt, 8'd0);
    tick;
    rst = 1'b0;
    run(-1, e);
    chk("rst_halt_edges", e, 3);
    chk("rst_halt_cnt", instr_cnt, 8'd0);
    tick;

    // Write and start in the same IDLE cycle.
    prog_we = 1'b1; prog_addr = 4'd0; prog_data = 8'h07;
    run(-1, e);
    chk("we_start_edges", e, 5);
    chk("we_start_cnt", instr_cnt, 8'd1);
    chk("we_start_y", y, 4'd7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
